// File: rtl/bus_params_pkg.sv
// Address and data widths shared by the memory-side interconnect.
package bus_params_pkg;
   localparam int unsigned BUS_AW = 32;
   localparam int unsigned BUS_DW = 32;
endpackage

// File: rtl/ibex_mem_arb_pkg.sv
// Shared types and the host-select function for the ibex_mem_arb memory arbiter.
package ibex_mem_arb_pkg;
   localparam int unsigned MAX_HOSTS = 8;

   typedef logic [2:0] host_id_t;

   // First requester at or after ptr, searching cyclically over MAX_HOSTS slots.
   // Callers zero the slots above N_HOST, which makes this a mod-N_HOST search.
   function automatic host_id_t arb_pick(input logic [MAX_HOSTS-1:0] req, input host_id_t ptr);
      host_id_t idx;
      host_id_t pick;
      pick = ptr;
      for (int i = MAX_HOSTS - 1; i >= 0; i--) begin
         idx = ptr + host_id_t'(i);
         if (req[idx]) pick = idx;
      end
      return pick;
   endfunction
endpackage

// File: rtl/ibex_mem_arb_id_fifo.sv
// In-order FIFO of host IDs: one entry per granted transaction still awaiting its rvalid.
module ibex_mem_arb_id_fifo
   import ibex_mem_arb_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  host_id_t         push_id_i,
   input  logic             pop_i,
   output host_id_t         head_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);
   host_id_t         mem_q [DEPTH];
   logic [PTR_W-1:0] wptr_q, rptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push, do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rptr_q];
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wptr_q <= ptr_inc(wptr_q);
         if (do_pop)  rptr_q <= ptr_inc(rptr_q);
         if (do_push && !do_pop) begin
            count_q <= count_q + CNT_W'(1);
         end else if (do_pop && !do_push) begin
            count_q <= count_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wptr_q] <= push_id_i;
   end
endmodule

// File: rtl/ibex_mem_arb.sv
// N_HOST-to-1 req/gnt/rvalid memory arbiter; responses are routed back in grant order.
// Define IBEX_MEM_ARB_RR_EN for round-robin selection; otherwise fixed priority, host 0 highest.
module ibex_mem_arb
   import ibex_mem_arb_pkg::*;
#(
   parameter int unsigned N_HOST          = 2,
   parameter int unsigned ADDR_WIDTH      = bus_params_pkg::BUS_AW,
   parameter int unsigned DATA_WIDTH      = bus_params_pkg::BUS_DW,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic [N_HOST-1:0]              host_req_i,
   output logic [N_HOST-1:0]              host_gnt_o,
   input  logic [N_HOST*ADDR_WIDTH-1:0]   host_addr_i,
   input  logic [N_HOST-1:0]              host_we_i,
   input  logic [N_HOST*DATA_WIDTH/8-1:0] host_be_i,
   input  logic [N_HOST*DATA_WIDTH-1:0]   host_wdata_i,
   output logic [N_HOST-1:0]              host_rvalid_o,
   output logic [DATA_WIDTH-1:0]          host_rdata_o,
   output logic                           mem_req_o,
   output logic [ADDR_WIDTH-1:0]          mem_addr_o,
   output logic                           mem_we_o,
   output logic [DATA_WIDTH/8-1:0]        mem_be_o,
   output logic [DATA_WIDTH-1:0]          mem_wdata_o,
   input  logic                           mem_gnt_i,
   input  logic                           mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0]          mem_rdata_i
);
   localparam int unsigned BE_W  = DATA_WIDTH / 8;
   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

   logic [MAX_HOSTS-1:0] req_ext;
   host_id_t             pick, sel, mux_idx, head;
   host_id_t             lock_idx_q, lock_idx_d;
   logic                 locked_q, locked_d;
   logic                 fifo_full, fifo_empty, grant, pop;
   logic [CNT_W-1:0]     fifo_count;

   always_comb begin
      req_ext = '0;
      req_ext[N_HOST-1:0] = host_req_i;
   end

`ifdef IBEX_MEM_ARB_RR_EN
   host_id_t rr_ptr_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_ptr_q <= '0;
      end else if (grant) begin
         rr_ptr_q <= (sel == host_id_t'(N_HOST - 1)) ? '0 : sel + host_id_t'(1);
      end
   end

   assign pick = arb_pick(req_ext, rr_ptr_q);
`else
   assign pick = arb_pick(req_ext, host_id_t'(0));
`endif

   // A stalled request keeps the port until memory accepts it.
   assign sel       = locked_q ? lock_idx_q : pick;
   assign mem_req_o = rst_ni & ~fifo_full & req_ext[sel];
   assign grant     = mem_req_o & mem_gnt_i;
   assign pop       = rst_ni & mem_rvalid_i & ~fifo_empty;

   assign host_rdata_o = mem_rdata_i;

   always_comb begin
      mux_idx     = rst_ni ? sel : host_id_t'(0);
      mem_addr_o  = host_addr_i[ADDR_WIDTH-1:0];
      mem_we_o    = host_we_i[0];
      mem_be_o    = host_be_i[BE_W-1:0];
      mem_wdata_o = host_wdata_i[DATA_WIDTH-1:0];
      for (int i = 1; i < N_HOST; i++) begin
         if (mux_idx == host_id_t'(i)) begin
            mem_addr_o  = host_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
            mem_we_o    = host_we_i[i];
            mem_be_o    = host_be_i[i*BE_W +: BE_W];
            mem_wdata_o = host_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      host_gnt_o    = '0;
      host_rvalid_o = '0;
      for (int i = 0; i < N_HOST; i++) begin
         if (sel == host_id_t'(i))  host_gnt_o[i]    = grant;
         if (head == host_id_t'(i)) host_rvalid_o[i] = pop;
      end
   end

   // Lock survives a full FIFO: mem_req_o drops but the selection stays frozen.
   always_comb begin
      locked_d   = locked_q;
      lock_idx_d = lock_idx_q;
      if (grant) begin
         locked_d = 1'b0;
      end else if (mem_req_o) begin
         locked_d   = 1'b1;
         lock_idx_d = sel;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         locked_q   <= 1'b0;
         lock_idx_q <= '0;
      end else begin
         locked_q   <= locked_d;
         lock_idx_q <= lock_idx_d;
      end
   end

   ibex_mem_arb_id_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_id_fifo (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .push_i    (grant),
      .push_id_i (sel),
      .pop_i     (pop),
      .head_o    (head),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .count_o   (fifo_count)
   );

`ifndef SYNTHESIS
   rvalid_with_outstanding_a : assert property (
      @(posedge clk_i) disable iff (!rst_ni) mem_rvalid_i |-> !fifo_empty)
      else $warning("ibex_mem_arb: rvalid with no outstanding grant, response dropped");

   count_in_range_a : assert property (
      @(posedge clk_i) disable iff (!rst_ni) fifo_count <= CNT_W'(MAX_OUTSTANDING));
`endif
endmodule

// File: tb/tb_ibex_mem_arb.sv
// Self-checking bench for ibex_mem_arb against a queue-based behavioural model.
module tb_ibex_mem_arb;
   localparam int N    = 2;
   localparam int MAXO = 4;
   localparam int AW   = bus_params_pkg::BUS_AW;
   localparam int DW   = bus_params_pkg::BUS_DW;
   localparam int BW   = DW / 8;
`ifdef IBEX_MEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req, gnt, we, rvalid;
   logic [N*AW-1:0] addr;
   logic [N*BW-1:0] be;
   logic [N*DW-1:0] wdata;
   logic [DW-1:0]   rdata;
   logic            mem_req, mem_we, mem_gnt, mem_rvalid;
   logic [AW-1:0]   mem_addr;
   logic [BW-1:0]   mem_be;
   logic [DW-1:0]   mem_wdata, mem_rdata;

   int n_cmp = 0;
   int n_err = 0;

   // Model: list of outstanding host IDs in grant order, lock state and RR pointer.
   int m_q[$];
   bit m_locked;
   int m_lock_idx;
   int m_ptr;

   always #5 clk = ~clk;

   ibex_mem_arb #(
      .N_HOST          (N),
      .ADDR_WIDTH      (AW),
      .DATA_WIDTH      (DW),
      .MAX_OUTSTANDING (MAXO)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .host_req_i    (req),
      .host_gnt_o    (gnt),
      .host_addr_i   (addr),
      .host_we_i     (we),
      .host_be_i     (be),
      .host_wdata_i  (wdata),
      .host_rvalid_o (rvalid),
      .host_rdata_o  (rdata),
      .mem_req_o     (mem_req),
      .mem_addr_o    (mem_addr),
      .mem_we_o      (mem_we),
      .mem_be_o      (mem_be),
      .mem_wdata_o   (mem_wdata),
      .mem_gnt_i     (mem_gnt),
      .mem_rvalid_i  (mem_rvalid),
      .mem_rdata_i   (mem_rdata)
   );

   function automatic int exp_pick();
      if (m_locked) return m_lock_idx;
      for (int k = 0; k < N; k++) begin
         if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
      end
      return -1;
   endfunction

   function automatic bit exp_mem_req();
      int idx;
      idx = exp_pick();
      return rst_n && (m_q.size() < MAXO) && (idx >= 0) && req[idx];
   endfunction

   task automatic model_clear();
      m_q.delete();
      m_locked   = 1'b0;
      m_lock_idx = 0;
      m_ptr      = 0;
   endtask

   // Advance the model with the inputs now applied, then step past the next edge.
   task automatic tick();
      int idx;
      bit mr;
      idx = exp_pick();
      mr  = exp_mem_req();
      if (mem_rvalid && m_q.size() > 0) void'(m_q.pop_front());
      if (mr && mem_gnt) begin
         m_q.push_back(idx);
         m_locked = 1'b0;
         if (RR) m_ptr = (idx + 1) % N;
      end else if (mr) begin
         m_locked   = 1'b1;
         m_lock_idx = idx;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n      = 1'b0;
      req        = '0;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      model_clear();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      model_clear();
      req        = '1;
      mem_gnt    = 1'b1;
      mem_rvalid = 1'b1;
      addr       = {32'h2222_0000, 32'h1111_0000};
      #2;
      n_cmp++;
      if (mem_req !== 1'b0) begin
         n_err++; $display("FAIL reset_mem_req: got %b want 0", mem_req);
      end
      n_cmp++;
      if (gnt !== 2'b00) begin
         n_err++; $display("FAIL reset_gnt: got %b want 00", gnt);
      end
      n_cmp++;
      if (rvalid !== 2'b00) begin
         n_err++; $display("FAIL reset_rvalid: got %b want 00", rvalid);
      end
      n_cmp++;
      if (mem_addr !== 32'h1111_0000) begin
         n_err++; $display("FAIL reset_addr: got %h want 11110000", mem_addr);
      end
      @(posedge clk);
      #1;
      rst_n      = 1'b1;
      mem_rvalid = 1'b0;
      #2;
      n_cmp++;
      if (gnt !== 2'b01) begin
         n_err++; $display("FAIL reset_first_gnt: got %b want 01", gnt);
      end
      tick();
   endtask

   task automatic test_contention();
      logic [N-1:0] eg, prev;
      apply_reset();
      req     = 2'b11;
      mem_gnt = 1'b1;
      prev    = '0;
      for (int i = 0; i < 6; i++) begin
         mem_rvalid = (m_q.size() > 0);
         #2;
         eg = RR ? ((i % 2 == 0) ? 2'b01 : 2'b10) : 2'b01;
         n_cmp++;
         if (gnt !== eg) begin
            n_err++; $display("FAIL contention_gnt[%0d]: got %b want %b", i, gnt, eg);
         end
         n_cmp++;
         if (rvalid !== prev) begin
            n_err++; $display("FAIL contention_rvalid[%0d]: got %b want %b", i, rvalid, prev);
         end
         prev = eg;
         tick();
      end
   endtask

   task automatic test_lock();
      logic [N-1:0] order [2];
      apply_reset();
      addr    = {32'hB000_0004, 32'hA000_0000};
      req     = 2'b10;
      mem_gnt = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #2;
         n_cmp++;
         if (mem_req !== 1'b1 || gnt !== 2'b00 || mem_addr !== 32'hB000_0004) begin
            n_err++;
            $display("FAIL lock_wait[%0d]: got req=%b gnt=%b addr=%h want req=1 gnt=00 addr=b0000004",
                     i, mem_req, gnt, mem_addr);
         end
         tick();
      end
      req = 2'b11;
      #2;
      n_cmp++;
      if (mem_addr !== 32'hB000_0004) begin
         n_err++; $display("FAIL lock_hold_addr: got %h want b0000004", mem_addr);
      end
      tick();
      mem_gnt = 1'b1;
      #2;
      n_cmp++;
      if (gnt !== 2'b10) begin
         n_err++; $display("FAIL lock_gnt: got %b want 10", gnt);
      end
      tick();
      req = 2'b01;
      #2;
      n_cmp++;
      if (gnt !== 2'b01) begin
         n_err++; $display("FAIL lock_release_gnt: got %b want 01", gnt);
      end
      tick();
      req        = '0;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b1;
      order      = '{2'b10, 2'b01};
      for (int i = 0; i < 2; i++) begin
         #2;
         n_cmp++;
         if (rvalid !== order[i]) begin
            n_err++; $display("FAIL lock_rvalid[%0d]: got %b want %b", i, rvalid, order[i]);
         end
         tick();
      end
      mem_rvalid = 1'b0;
   endtask

   task automatic test_full();
      int           seq [4];
      int           ord [4];
      logic [N-1:0] eg;
      logic [DW-1:0] d;
      apply_reset();
      seq     = '{0, 1, 1, 0};
      mem_gnt = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req = '0;
         req[seq[i]] = 1'b1;
         eg = '0;
         eg[seq[i]] = 1'b1;
         #2;
         n_cmp++;
         if (gnt !== eg) begin
            n_err++; $display("FAIL full_fill_gnt[%0d]: got %b want %b", i, gnt, eg);
         end
         tick();
      end
      req = 2'b01;
      #2;
      n_cmp++;
      if (mem_req !== 1'b0 || gnt !== 2'b00) begin
         n_err++; $display("FAIL full_block: got req=%b gnt=%b want req=0 gnt=00", mem_req, gnt);
      end
      tick();
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hA5A5_A5A5;
      #2;
      n_cmp++;
      if (rvalid !== 2'b01 || rdata !== 32'hA5A5_A5A5) begin
         n_err++; $display("FAIL full_pop: got rvalid=%b rdata=%h want 01 a5a5a5a5", rvalid, rdata);
      end
      n_cmp++;
      if (mem_req !== 1'b0) begin
         n_err++; $display("FAIL full_pop_same_cycle_req: got %b want 0", mem_req);
      end
      tick();
      mem_rvalid = 1'b0;
      #2;
      n_cmp++;
      if (mem_req !== 1'b1 || gnt !== 2'b01) begin
         n_err++; $display("FAIL full_reopen: got req=%b gnt=%b want req=1 gnt=01", mem_req, gnt);
      end
      tick();
      req        = '0;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b1;
      ord        = '{1, 1, 0, 0};
      for (int i = 0; i < 4; i++) begin
         d         = DW'($urandom);
         mem_rdata = d;
         eg        = '0;
         eg[ord[i]] = 1'b1;
         #2;
         n_cmp++;
         if (rvalid !== eg || rdata !== d) begin
            n_err++;
            $display("FAIL full_order[%0d]: got rvalid=%b rdata=%h want %b %h", i, rvalid, rdata, eg, d);
         end
         tick();
      end
      mem_rvalid = 1'b0;
   endtask

   task automatic test_reset_midstream();
      apply_reset();
      req     = 2'b01;
      mem_gnt = 1'b1;
      tick();
      tick();
      req     = '0;
      mem_gnt = 1'b0;
      #2;
      rst_n = 1'b0;
      model_clear();
      @(posedge clk);
      #1;
      rst_n      = 1'b1;
      mem_rvalid = 1'b1;
      #2;
      n_cmp++;
      if (rvalid !== 2'b00) begin
         n_err++; $display("FAIL midreset_stray_rvalid: got %b want 00", rvalid);
      end
      tick();
      mem_rvalid = 1'b0;
      req        = 2'b01;
      mem_gnt    = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #2;
         n_cmp++;
         if (mem_req !== 1'b1) begin
            n_err++; $display("FAIL midreset_refill_req[%0d]: got %b want 1", i, mem_req);
         end
         tick();
      end
      #2;
      n_cmp++;
      if (mem_req !== 1'b0) begin
         n_err++; $display("FAIL midreset_full_req: got %b want 0", mem_req);
      end
      tick();
   endtask

   task automatic test_random();
      logic [N-1:0]  last_g, eg, er;
      int            idx;
      bit            mr;
      apply_reset();
      last_g = '0;
      for (int c = 0; c < 400; c++) begin
         for (int h = 0; h < N; h++) begin
            // A host holds its request and fields until granted.
            if (!(req[h] && !last_g[h])) begin
               req[h]              = 1'($urandom_range(0, 1));
               we[h]               = 1'($urandom_range(0, 1));
               addr[h*AW +: AW]    = AW'($urandom);
               be[h*BW +: BW]      = BW'($urandom);
               wdata[h*DW +: DW]   = DW'($urandom);
            end
         end
         mem_gnt    = ($urandom_range(0, 3) != 0);
         mem_rvalid = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
         mem_rdata  = DW'($urandom);
         #2;
         idx = exp_pick();
         mr  = exp_mem_req();
         eg  = '0;
         er  = '0;
         if (mr && mem_gnt) eg[idx] = 1'b1;
         if (mem_rvalid && m_q.size() > 0) er[m_q[0]] = 1'b1;
         n_cmp++;
         if (mem_req !== mr || gnt !== eg || rvalid !== er) begin
            n_err++;
            $display("FAIL rand_ctrl[%0d]: got req=%b gnt=%b rvalid=%b want req=%b gnt=%b rvalid=%b",
                     c, mem_req, gnt, rvalid, mr, eg, er);
         end
         if (er != '0) begin
            n_cmp++;
            if (rdata !== mem_rdata) begin
               n_err++; $display("FAIL rand_rdata[%0d]: got %h want %h", c, rdata, mem_rdata);
            end
         end
         if (mr) begin
            n_cmp++;
            if (mem_addr !== addr[idx*AW +: AW] || mem_we !== we[idx] ||
                mem_be !== be[idx*BW +: BW] || mem_wdata !== wdata[idx*DW +: DW]) begin
               n_err++;
               $display("FAIL rand_fields[%0d]: got %h/%b/%h/%h want host %0d %h/%b/%h/%h", c,
                        mem_addr, mem_we, mem_be, mem_wdata, idx, addr[idx*AW +: AW], we[idx],
                        be[idx*BW +: BW], wdata[idx*DW +: DW]);
            end
         end
         last_g = eg;
         tick();
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      req        = '0;
      we         = '0;
      addr       = '0;
      be         = '0;
      wdata      = '0;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      model_clear();
      #3;
      test_reset();
      test_contention();
      test_lock();
      test_full();
      test_reset_midstream();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/ibex_mem_arb.md
# ibex_mem_arb

Arbitrates N_HOST request/grant/rvalid memory hosts onto a single downstream memory port of the same protocol, e.g. the instruction and data ports of a core sharing one memory model or SRAM. Selects one requesting host per cycle, holds that choice until the memory grants it, and records the granted host ID in an in-order FIFO so each `rvalid` is routed back to its issuer. Sits between bus agents/cores and the memory responder, on the `bus_params_pkg` address and data widths.

## Interface
- `N_HOST`, 2: number of upstream hosts (2..8).
- `ADDR_WIDTH`, `bus_params_pkg::BUS_AW`: address width.
- `DATA_WIDTH`, `bus_params_pkg::BUS_DW`: data width; byte enables are `DATA_WIDTH/8`.
- `MAX_OUTSTANDING`, 4: granted-but-unanswered transactions allowed (power of two, ≥1).

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; one clock; reset is asynchronous and active-low.
- `host_req_i`  in  N_HOST  per-host request.
- `host_gnt_o`  out  N_HOST  per-host grant.
- `host_addr_i`  in  N_HOST*ADDR_WIDTH  packed addresses, host 0 in LSBs.
- `host_we_i`  in  N_HOST  write enable.
- `host_be_i`  in  N_HOST*DATA_WIDTH/8  byte enables.
- `host_wdata_i`  in  N_HOST*DATA_WIDTH  write data.
- `host_rvalid_o`  out  N_HOST  per-host response valid.
- `host_rdata_o`  out  DATA_WIDTH  response data, broadcast; qualified by `host_rvalid_o`.
- `mem_req_o`, `mem_addr_o`, `mem_we_o`, `mem_be_o`, `mem_wdata_o`  out  downstream request fields.
- `mem_gnt_i`, `mem_rvalid_i`  in  1  downstream grant/response valid.
- `mem_rdata_i`  in  DATA_WIDTH  downstream read data.

## Operation
- Protocol: a host holds `req` and all request fields stable until `gnt`. Each grant yields exactly one `rvalid`, in grant order. A write's response carries no meaningful data.
- Arbitration: when not locked and the FIFO is not full, select a requesting host by the configured policy. `mem_req_o`=1 and `mem_*` fields come from the selected host.
- Lock: if `mem_req_o`=1 and `mem_gnt_i`=0, set `locked`/`lock_idx` at the clock edge. While locked the selection is frozen to `lock_idx`, even if higher-priority hosts request. Lock clears on the cycle `mem_gnt_i`=1.
- Grant: `host_gnt_o[sel] = mem_gnt_i & mem_req_o`. All other grant bits are 0.
- On a grant, push `sel` into the ID FIFO (depth MAX_OUTSTANDING).
- Response: when `mem_rvalid_i`=1, pop the FIFO head, drive `host_rvalid_o[head]`=1, and pass `mem_rdata_i` to `host_rdata_o`.
- Full: when the FIFO count equals MAX_OUTSTANDING, force `mem_req_o`=0.
  - A pop in the same cycle does not reopen the port; requests resume the next cycle.
  - If the FIFO fills while locked, the lock is preserved.
- Push and pop in the same cycle: count is unchanged and both operations take effect.
- `mem_rvalid_i` with an empty FIFO is a protocol error: the response is dropped, no `host_rvalid_o` is raised, and a simulation assertion fires.
- Reset mid-operation clears the FIFO, count, lock and RR pointer. Outstanding responses are discarded.

## Timing
- Request path is combinational: host request to `mem_req_o` and grant back in the same cycle (0-cycle added latency).
- Response path is combinational: `mem_rvalid_i` to `host_rvalid_o` in the same cycle.
- State updates on `posedge clk_i`. Reset values:
  - `host_gnt_o`=0, `host_rvalid_o`=0, `mem_req_o`=0 (all forced while `rst_ni`=0).
  - `mem_addr_o`/`mem_we_o`/`mem_be_o`/`mem_wdata_o`/`host_rdata_o` take the combinational values of host 0 and `mem_rdata_i`.
  - Internal: count=0, `locked`=0, RR pointer=0.
- FIFO pointers are `$clog2(MAX_OUTSTANDING)` bits and wrap modulo depth. Count is one bit wider.

## Configuration
- `IBEX_MEM_ARB_RR_EN` defined: round-robin. The pointer advances to `sel+1` (mod N_HOST) after each grant, and the search starts at the pointer.
- Undefined: fixed priority, lowest index wins, and there is no pointer register.
- Lock behaviour is identical in both modes.

## Structure
- Package `ibex_mem_arb_pkg` holds:
  - `MAX_HOSTS` = 8.
  - `host_id_t` (`logic [2:0]`).
  - The arbitration-select function `arb_pick(req, ptr)`.
- Sub-module `ibex_mem_arb_id_fifo`: a synchronous FIFO of `host_id_t` with push/pop/full/empty/count. The arbiter top holds the lock and the selection logic.

## Test plan
- Reset: assert `rst_ni`=0 with all `host_req_i`=1 → `mem_req_o`=0 and grants 0. Release → host 0 is granted first.
- Contention, fixed priority: `host_req_i`=2'b11 and `mem_gnt_i` always 1 → host 0 is granted on every cycle and host 1 starves.
- Contention, RR: same stimulus → grants alternate 0,1,0,1.
- Lock: host 1 requests alone with `mem_gnt_i`=0 for 3 cycles, then host 0 also requests → host 1 stays selected and is granted at the first `mem_gnt_i`=1.
- Full: MAX_OUTSTANDING=4, four grants with no `rvalid` → `mem_req_o`=0.
  - One `mem_rvalid_i` → `mem_req_o`=1 the following cycle.
  - Responses route to hosts in grant order, e.g. 0,1,1,0 with `host_rdata_o`=0xA5A5A5A5 on the matching cycle.
- Reset mid-stream with 2 outstanding → count=0 after release; a stray `mem_rvalid_i` raises no `host_rvalid_o` and fires the assertion.
